// File: rtl/regfile_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl_if
//   Bundles the signals between the access controller and its neighbours. The
//   instruction handshake comes from the decoder. The read/write ports go to
//   the 8x8 register file.
//
//   Modports
//     master : decoder + register-file side (drives instructions, read data)
//     slave  : regfile_access_ctrl side (drives ready, register-file ports)
//
//   Signals
//     instr_valid / instr_ready      instruction handshake
//     opcode, dest, src1, src2, imm  decoded instruction fields
//     rf_rd_addr1/2, rf_rd_data1/2   two combinational read ports
//     rf_wr_en, rf_wr_addr, rf_wr_data  write port (falling-edge commit)
// -----------------------------------------------------------------------------
interface regfile_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] imm;

    logic [ADDR_W-1:0] rf_rd_addr1;
    logic [ADDR_W-1:0] rf_rd_addr2;
    logic [DATA_W-1:0] rf_rd_data1;
    logic [DATA_W-1:0] rf_rd_data2;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    modport master (
        output instr_valid, opcode, dest, src1, src2, imm,
        output rf_rd_data1, rf_rd_data2,
        input  instr_ready,
        input  rf_rd_addr1, rf_rd_addr2,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  instr_valid, opcode, dest, src1, src2, imm,
        input  rf_rd_data1, rf_rd_data2,
        output instr_ready,
        output rf_rd_addr1, rf_rd_addr2,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
//   Runs one instruction at a time against an 8x8 register file. The sequence
//   is IDLE -> READ -> EXEC -> WRITE, with one cycle in each non-IDLE state.
//   The instruction is accepted in IDLE. Both source registers are captured in
//   READ. A small ALU result and its flags are registered in EXEC. The result
//   is presented on the write port during WRITE, and the register file commits
//   it on the falling clock edge in the middle of that cycle.
//
//   Ports
//     clk      in   system clock, rising-edge state updates
//     rst_n    in   asynchronous active-low reset
//     bus      slave modport of regfile_access_ctrl_if (handshake + regfile)
//     done     out  one-cycle pulse while in WRITE (instruction retired)
//     zero     out  result==0 of the last legal ALU op
//     carry    out  carry (ADD) / borrow (SUB) of the last legal ALU op
//     illegal  out  last instruction used the reserved opcode
// -----------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_access_ctrl_if.slave bus,
    output logic                 done,
    output logic                 zero,
    output logic                 carry,
    output logic                 illegal
);

    localparam logic [2:0] OP_LOADI = 3'b000;
    localparam logic [2:0] OP_MOV   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Latched instruction fields.
    logic [2:0]        opcode_reg;
    logic [ADDR_W-1:0] dest_reg;
    logic [ADDR_W-1:0] src1_reg;
    logic [ADDR_W-1:0] src2_reg;
    logic [DATA_W-1:0] imm_reg;

    // Operands, result and flags.
    logic [DATA_W-1:0] op_a_reg;
    logic [DATA_W-1:0] op_b_reg;
    logic [DATA_W-1:0] result_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              zero_reg;
    logic              carry_reg;
    logic              illegal_reg;

    // FSM-decoded controls.
    logic accept;
    logic in_read;
    logic in_exec;
    logic in_write;

    // ALU combinational outputs.
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_illegal;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] and_v;
    logic [DATA_W-1:0] or_v;
    logic [DATA_W-1:0] xor_v;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        in_read    = 1'b0;
        in_exec    = 1'b0;
        in_write   = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                accept = bus.instr_valid;
                if (bus.instr_valid) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                in_read    = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                in_exec    = 1'b1;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                in_write   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Ready and the write strobe are decoded from the state register. An
    // asynchronous reset forces state_reg to IDLE, so rf_wr_en falls at once
    // and a write in flight never reaches its falling-edge commit.
    assign bus.instr_ready = (state_reg == S_IDLE);
    assign bus.rf_wr_en    = in_write && !illegal_reg;
    assign done            = in_write;

    // -------------------------------------------------------------------------
    // Instruction latch and operand capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_reg <= '0;
            dest_reg   <= '0;
            src1_reg   <= '0;
            src2_reg   <= '0;
            imm_reg    <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
        end else begin
            if (accept) begin
                opcode_reg <= bus.opcode;
                dest_reg   <= bus.dest;
                src1_reg   <= bus.src1;
                src2_reg   <= bus.src2;
                imm_reg    <= bus.imm;
            end
            if (in_read) begin
                op_a_reg <= bus.rf_rd_data1;
                op_b_reg <= bus.rf_rd_data2;
            end
        end
    end

    // The source latches change only on accept, which is also the entry into
    // READ. Driving the read addresses straight from them gives the required
    // "hold last value" behaviour outside READ.
    assign bus.rf_rd_addr1 = src1_reg;
    assign bus.rf_rd_addr2 = src2_reg;

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    // The extra MSB of the widened sum/difference is the carry-out for ADD and
    // the borrow (op_a < op_b) for SUB.
    assign sum_ext  = {1'b0, op_a_reg} + {1'b0, op_b_reg};
    assign diff_ext = {1'b0, op_a_reg} - {1'b0, op_b_reg};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bitwise
            assign and_v[gi] = op_a_reg[gi] & op_b_reg[gi];
            assign or_v[gi]  = op_a_reg[gi] | op_b_reg[gi];
            assign xor_v[gi] = op_a_reg[gi] ^ op_b_reg[gi];
        end
    endgenerate

    always_comb begin
        alu_result  = result_reg;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        unique case (opcode_reg)
            OP_LOADI: alu_result = imm_reg;
            OP_MOV:   alu_result = op_a_reg;
            OP_ADD: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_carry  = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_carry  = diff_ext[DATA_W];
            end
            OP_AND:   alu_result = and_v;
            OP_OR:    alu_result = or_v;
            OP_XOR:   alu_result = xor_v;
            default:  alu_illegal = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Result, flags and write port registers (loaded at the end of EXEC)
    // -------------------------------------------------------------------------
    // A reserved opcode only raises illegal. The result, zero and carry keep
    // their previous values. The write address still tracks dest so the write
    // port reflects the retired instruction, but rf_wr_en stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg  <= '0;
            wr_addr_reg <= '0;
            zero_reg    <= 1'b0;
            carry_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (in_exec) begin
            illegal_reg <= alu_illegal;
            wr_addr_reg <= dest_reg;
            if (!alu_illegal) begin
                result_reg <= alu_result;
                zero_reg   <= (alu_result == '0);
                carry_reg  <= alu_carry;
            end
        end
    end

    assign bus.rf_wr_addr = wr_addr_reg;
    assign bus.rf_wr_data = result_reg;
    assign zero           = zero_reg;
    assign carry          = carry_reg;
    assign illegal        = illegal_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_ctrl
//   Directed and random instructions for regfile_access_ctrl. The bench holds a
//   small register-file model that the DUT drives. It also keeps an independent
//   reference array and computes expected results from the opcode table.
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done, zero, carry, illegal;

    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_access_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .done    (done),
        .zero    (zero),
        .carry   (carry),
        .illegal (illegal)
    );

    // Register file: combinational reads, write commits on the falling edge.
    logic [7:0] rf_mem [8] = '{default: 8'h00};
    assign bus.rf_rd_data1 = rf_mem[bus.rf_rd_addr1];
    assign bus.rf_rd_data2 = rf_mem[bus.rf_rd_addr2];
    always @(negedge clk) begin
        if (bus.rf_wr_en) rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
    end

    // Reference model state.
    logic [7:0] ref_rf [8] = '{default: 8'h00};
    logic [7:0] ref_last = 8'h00;
    logic       ref_zero = 1'b0;
    logic       ref_carry = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Opcode table evaluated with plain arithmetic on the reference registers.
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] imm_v, output logic [7:0] res,
                         output logic c, output logic legal);
        int unsigned ai, bi;
        ai = a;
        bi = b;
        legal = 1'b1;
        c     = 1'b0;
        res   = ref_last;
        case (op)
            3'd0: res = imm_v;
            3'd1: res = a;
            3'd2: begin res = 8'((ai + bi) % 256); c = (ai + bi) > 255; end
            3'd3: begin res = 8'((ai + 256 - bi) % 256); c = ai < bi; end
            3'd4: res = a & b;
            3'd5: res = a | b;
            3'd6: res = a ^ b;
            default: legal = 1'b0;
        endcase
    endtask

    // One instruction from IDLE to IDLE, checking every stage.
    task automatic run_instr(input string name, input logic [2:0] op, input logic [2:0] d,
                             input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] imm_v);
        logic [7:0] res;
        logic c, legal;
        model(op, ref_rf[s1], ref_rf[s2], imm_v, res, c, legal);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = op; bus.dest = d; bus.src1 = s1; bus.src2 = s2; bus.imm = imm_v;
        chk({name, ".ready_idle"}, 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk({name, ".ready_read"}, 32'(bus.instr_ready), 32'd0);
        chk({name, ".rd_addr1"}, 32'(bus.rf_rd_addr1), 32'(s1));
        chk({name, ".rd_addr2"}, 32'(bus.rf_rd_addr2), 32'(s2));
        @(posedge clk); #1;
        chk({name, ".wr_en_exec"}, 32'(bus.rf_wr_en), 32'd0);
        chk({name, ".done_exec"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        chk({name, ".done_write"}, 32'(done), 32'd1);
        chk({name, ".wr_en"}, 32'(bus.rf_wr_en), 32'(legal));
        chk({name, ".wr_addr"}, 32'(bus.rf_wr_addr), 32'(d));
        chk({name, ".wr_data"}, 32'(bus.rf_wr_data), 32'(res));
        chk({name, ".illegal"}, 32'(illegal), 32'(!legal));
        if (legal) begin
            ref_rf[d] = res;
            ref_last  = res;
            ref_zero  = (res == 8'h00);
            ref_carry = c;
        end
        chk({name, ".zero"}, 32'(zero), 32'(ref_zero));
        chk({name, ".carry"}, 32'(carry), 32'(ref_carry));
        @(posedge clk); #1;
        chk({name, ".done_after"}, 32'(done), 32'd0);
        chk({name, ".ready_after"}, 32'(bus.instr_ready), 32'd1);
        chk({name, ".regfile"}, 32'(rf_mem[d]), 32'(ref_rf[d]));
        $display("instr %s op=%0d d=%0d s1=%0d s2=%0d imm=%0h -> res=%0h legal=%0d",
                 name, op, d, s1, s2, imm_v, res, legal);
    endtask

    initial begin
        logic [7:0] res;
        logic c, legal;
        logic [2:0] q_op [3];
        logic [2:0] q_d [3];
        logic [2:0] q_s1 [3];
        logic [2:0] q_s2 [3];
        logic [7:0] q_imm [3];
        int idx;

        bus.instr_valid = 1'b0;
        bus.opcode = 3'd0; bus.dest = 3'd0; bus.src1 = 3'd0; bus.src2 = 3'd0; bus.imm = 8'h00;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(bus.instr_ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst.flags", {29'd0, zero, carry, illegal}, 32'd0);
        chk("rst.wr_data", 32'(bus.rf_wr_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: LOADI r0=7, LOADI r1=2, ADD r2=r0+r1.
        run_instr("t1_ld0", 3'd0, 3'd0, 3'd0, 3'd0, 8'd7);
        run_instr("t1_ld1", 3'd0, 3'd1, 3'd0, 3'd0, 8'd2);
        run_instr("t1_add", 3'd2, 3'd2, 3'd0, 3'd1, 8'd0);
        // 2: SUB r3=r1-r0 -> FB with borrow.
        run_instr("t2_sub", 3'd3, 3'd3, 3'd1, 3'd0, 8'd0);
        // 3: FF + 01 wraps to zero with carry.
        run_instr("t3_ld4", 3'd0, 3'd4, 3'd0, 3'd0, 8'hFF);
        run_instr("t3_ld5", 3'd0, 3'd5, 3'd0, 3'd0, 8'h01);
        run_instr("t3_add", 3'd2, 3'd6, 3'd4, 3'd5, 8'd0);
        // 5: reserved opcode against r3, then an ordinary op.
        run_instr("t5_ill", 3'd7, 3'd3, 3'd1, 3'd2, 8'h5A);
        run_instr("t5_xor", 3'd6, 3'd7, 3'd3, 3'd0, 8'd0);

        // 6: reset during EXEC of ADD r2=r4+r0 (would write 06).
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 3'd2; bus.dest = 3'd2; bus.src1 = 3'd4; bus.src2 = 3'd0;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6.ready", 32'(bus.instr_ready), 32'd1);
        chk("t6.wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("t6.done", 32'(done), 32'd0);
        chk("t6.flags", {29'd0, zero, carry, illegal}, 32'd0);
        chk("t6.rd_addr1", 32'(bus.rf_rd_addr1), 32'd0);
        chk("t6.wr_data", 32'(bus.rf_wr_data), 32'd0);
        repeat (2) @(negedge clk);
        chk("t6.r2_kept", 32'(rf_mem[2]), 32'(ref_rf[2]));
        rst_n = 1'b1;
        ref_last = 8'h00; ref_zero = 1'b0; ref_carry = 1'b0;
        @(posedge clk); #1;
        chk("t6.ready_after", 32'(bus.instr_ready), 32'd1);
        $display("instr t6_reset aborted ADD r2, r2=%0h", rf_mem[2]);
        run_instr("t6_mov", 3'd1, 3'd0, 3'd2, 3'd0, 8'd0);

        // 4: instr_valid held high over a dependent chain of three.
        q_op  = '{3'd0, 3'd2, 3'd3};
        q_d   = '{3'd3, 3'd4, 3'd5};
        q_s1  = '{3'd0, 3'd3, 3'd4};
        q_s2  = '{3'd0, 3'd3, 3'd3};
        q_imm = '{8'($urandom_range(1, 255)), 8'h00, 8'h00};
        idx = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = q_op[0]; bus.dest = q_d[0]; bus.src1 = q_s1[0];
        bus.src2 = q_s2[0]; bus.imm = q_imm[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk("t4.ready", 32'(bus.instr_ready), 32'((cyc % 4) == 0));
            chk("t4.done", 32'(done), 32'((cyc % 4) == 3));
            @(posedge clk); #1;
            if ((cyc % 4) == 0) begin
                model(q_op[idx], ref_rf[q_s1[idx]], ref_rf[q_s2[idx]], q_imm[idx], res, c, legal);
                ref_rf[q_d[idx]] = res;
                ref_last = res;
                $display("instr t4_%0d accepted at edge %0d res=%0h", idx, cyc, res);
                idx++;
                if (idx < 3) begin
                    bus.opcode = q_op[idx]; bus.dest = q_d[idx]; bus.src1 = q_s1[idx];
                    bus.src2 = q_s2[idx]; bus.imm = q_imm[idx];
                end else begin
                    bus.instr_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk("t4.regfile", 32'(rf_mem[q_d[k]]), 32'(ref_rf[q_d[k]]));
        end
        // Flags of the final SUB in the chain, for the random phase to follow.
        ref_zero  = (ref_last == 8'h00);
        ref_carry = ref_rf[4] < ref_rf[3];

        // Random instructions against the reference model.
        for (int n = 0; n < 24; n++) begin
            run_instr($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
